// File: rtl/eight_queen_board_checker_if.sv
// rtl/eight_queen_board_checker_if.sv - row stream and result bundle between a board source and the checker
interface eight_queen_board_checker_if;
  logic       in_valid;
  logic [7:0] in_bus;
  logic       ready;
  logic       busy;
  logic       done;
  logic       legal;
  logic [1:0] fault_kind;
  logic [2:0] fault_a;
  logic [2:0] fault_b;
  logic       overrun;

  modport master (
    output in_valid, in_bus,
    input  ready, busy, done, legal, fault_kind, fault_a, fault_b, overrun
  );

  modport slave (
    input  in_valid, in_bus,
    output ready, busy, done, legal, fault_kind, fault_a, fault_b, overrun
  );
endinterface

// File: rtl/eight_queen_board_checker.sv
// rtl/eight_queen_board_checker.sv - captures eight one-hot board rows and checks them for a legal eight-queen placement
module eight_queen_board_checker (
  input logic                        clk,
  input logic                        reset,
  eight_queen_board_checker_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_CHECK, S_REPORT} state_e;

  state_e     state_q, state_d;
  logic [7:0] rows_q [8];
  logic [3:0] cnt_q;
  logic [2:0] i_q, j_q;
  logic       pend_q;
  logic [2:0] pend_row_q;
  logic       legal_q;
  logic [1:0] kind_q;
  logic [2:0] fa_q, fb_q;
  logic       overrun_q;

  logic       start, capture, in_onehot;
  logic [2:0] cap_idx, col_i, col_j;
  logic [3:0] col_diff, row_diff;
  logic       pair_col, pair_diag, last_pair;

  function automatic logic [2:0] enc(input logic [7:0] b);
    logic [2:0] r;
    r = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) r = 3'(k);
    end
    return r;
  endfunction

  always_comb begin
    start     = bus.in_valid && (state_q == S_IDLE || state_q == S_REPORT);
    capture   = start || (bus.in_valid && state_q == S_COLLECT);
    cap_idx   = start ? 3'd0 : cnt_q[2:0];
    in_onehot = (bus.in_bus != 8'd0) && ((bus.in_bus & (bus.in_bus - 8'd1)) == 8'd0);
    col_i     = enc(rows_q[i_q]);
    col_j     = enc(rows_q[j_q]);
    col_diff  = (col_i > col_j) ? ({1'b0, col_i} - {1'b0, col_j})
                                : ({1'b0, col_j} - {1'b0, col_i});
    row_diff  = {1'b0, j_q} - {1'b0, i_q};
    pair_col  = (col_i == col_j);
    pair_diag = !pair_col && (col_diff == row_diff);
    last_pair = (i_q == 3'd6) && (j_q == 3'd7);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.in_valid) state_d = S_COLLECT;
      S_COLLECT: if (bus.in_valid && cnt_q == 4'd7) state_d = S_CHECK;
      S_CHECK:   if (pend_q || pair_col || pair_diag || last_pair) state_d = S_REPORT;
      S_REPORT:  if (bus.in_valid) state_d = S_COLLECT;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 8; r++) rows_q[r] <= 8'd0;
      cnt_q      <= 4'd0;
      i_q        <= 3'd0;
      j_q        <= 3'd0;
      pend_q     <= 1'b0;
      pend_row_q <= 3'd0;
      legal_q    <= 1'b0;
      kind_q     <= 2'b00;
      fa_q       <= 3'd0;
      fb_q       <= 3'd0;
      overrun_q  <= 1'b0;
    end else begin
      if (capture) begin
        rows_q[cap_idx] <= bus.in_bus;
        cnt_q           <= start ? 4'd1 : cnt_q + 4'd1;
      end
      // Only the first malformed row is remembered; later rows are still stored.
      if (start) begin
        pend_q     <= !in_onehot;
        pend_row_q <= 3'd0;
        legal_q    <= 1'b0;
        kind_q     <= 2'b00;
        fa_q       <= 3'd0;
        fb_q       <= 3'd0;
        overrun_q  <= 1'b0;
        i_q        <= 3'd0;
        j_q        <= 3'd1;
      end else if (capture && !in_onehot && !pend_q) begin
        pend_q     <= 1'b1;
        pend_row_q <= cap_idx;
      end
      if (state_q == S_CHECK) begin
        if (bus.in_valid) overrun_q <= 1'b1;
        if (pend_q) begin
          kind_q <= 2'b01;
          fa_q   <= pend_row_q;
          fb_q   <= pend_row_q;
        end else if (pair_col) begin
          kind_q <= 2'b10;
          fa_q   <= i_q;
          fb_q   <= j_q;
        end else if (pair_diag) begin
          kind_q <= 2'b11;
          fa_q   <= i_q;
          fb_q   <= j_q;
        end else if (last_pair) begin
          legal_q <= 1'b1;
        end else if (j_q == 3'd7) begin
          i_q <= i_q + 3'd1;
          j_q <= i_q + 3'd2;
        end else begin
          j_q <= j_q + 3'd1;
        end
      end
    end
  end

  always_comb begin
    bus.ready      = (state_q == S_IDLE) || (state_q == S_REPORT);
    bus.busy       = (state_q == S_COLLECT) || (state_q == S_CHECK);
    bus.done       = (state_q == S_REPORT);
    bus.legal      = legal_q;
    bus.fault_kind = kind_q;
    bus.fault_a    = fa_q;
    bus.fault_b    = fb_q;
    bus.overrun    = overrun_q;
  end

endmodule

// File: tb/tb_eight_queen_board_checker.sv
// tb/tb_eight_queen_board_checker.sv - scoreboard bench for the eight-queen board checker
module tb_eight_queen_board_checker;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  eight_queen_board_checker_if bif ();

  eight_queen_board_checker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       legal;
    logic [1:0] kind;
    logic [2:0] fa;
    logic [2:0] fb;
    int         lat;
    logic       ovr;
  } exp_t;

  exp_t sb [$];

  localparam logic [63:0] LEGAL = {8'h08, 8'h02, 8'h40, 8'h04, 8'h20, 8'h80, 8'h10, 8'h01};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] brd, input logic ovr);
    exp_t       e;
    logic [7:0] b;
    int         col [8];
    int         n;
    int         d;
    e.legal = 1'b0; e.kind = 2'b00; e.fa = 3'd0; e.fb = 3'd0; e.lat = 1; e.ovr = ovr;
    for (int r = 0; r < 8; r++) begin
      b = brd[8*r +: 8];
      if ($countones(b) != 1) begin
        e.kind = 2'b01; e.fa = 3'(r); e.fb = 3'(r);
        return e;
      end
      for (int c = 0; c < 8; c++) if (b[c]) col[r] = c;
    end
    n = 0;
    for (int i = 0; i < 7; i++) begin
      for (int j = i + 1; j < 8; j++) begin
        n++;
        d = (col[j] > col[i]) ? col[j] - col[i] : col[i] - col[j];
        if (col[i] == col[j] || d == j - i) begin
          e.kind = (col[i] == col[j]) ? 2'b10 : 2'b11;
          e.fa = 3'(i); e.fb = 3'(j); e.lat = n;
          return e;
        end
      end
    end
    e.legal = 1'b1; e.lat = 28;
    return e;
  endfunction

  task automatic stream(input logic [63:0] brd, input int gap);
    for (int r = 0; r < 8; r++) begin
      bif.in_valid = 1'b1;
      bif.in_bus   = brd[8*r +: 8];
      @(negedge clk);
      if (r == 0) begin
        check_val("ovr_clr", 32'(bif.overrun), 32'd0);
        check_val("busy_collect", 32'(bif.busy), 32'd1);
      end
      if (r == 3) begin
        for (int g = 0; g < gap; g++) begin
          bif.in_valid = 1'b0;
          @(negedge clk);
        end
      end
    end
    bif.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int pulse);
    int   n;
    exp_t e;
    n = 0;
    while (!bif.done && n < 100) begin
      if (pulse > 0 && n == pulse) begin
        bif.in_valid = 1'b1;
        bif.in_bus   = 8'hff;
      end else begin
        bif.in_valid = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bif.in_valid = 1'b0;
    if (n >= 100) begin
      check_val("timeout", 32'(n), 32'd0);
      return;
    end
    if (sb.size() == 0) begin
      check_val("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check_val("latency", 32'(n), 32'(e.lat));
    check_val("legal", 32'(bif.legal), 32'(e.legal));
    check_val("kind", 32'(bif.fault_kind), 32'(e.kind));
    check_val("fault_a", 32'(bif.fault_a), 32'(e.fa));
    check_val("fault_b", 32'(bif.fault_b), 32'(e.fb));
    check_val("overrun", 32'(bif.overrun), 32'(e.ovr));
    check_val("ready_rep", 32'(bif.ready), 32'd1);
    check_val("busy_rep", 32'(bif.busy), 32'd0);
  endtask

  task automatic run(input logic [63:0] brd, input int gap, input int pulse);
    sb.push_back(model(brd, pulse > 0));
    stream(brd, gap);
    wait_done(pulse);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_ready"}, 32'(bif.ready), 32'd1);
    check_val({tag, "_busy"}, 32'(bif.busy), 32'd0);
    check_val({tag, "_done"}, 32'(bif.done), 32'd0);
    check_val({tag, "_outs"}, {21'd0, bif.legal, bif.fault_kind, bif.fault_a, bif.fault_b, bif.overrun}, 32'd0);
  endtask

  logic [63:0] brd;
  exp_t        ex;
  int          perm [8];
  int          k;
  int          t;

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bif.in_valid = 1'b0;
    bif.in_bus   = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_state("rst");

    // Fixed expectations for the legal reference board and the known faults.
    ex = '{legal: 1'b1, kind: 2'b00, fa: 3'd0, fb: 3'd0, lat: 28, ovr: 1'b0};
    sb.push_back(ex);
    stream(LEGAL, 0);
    wait_done(0);

    ex = '{legal: 1'b0, kind: 2'b11, fa: 3'd0, fb: 3'd1, lat: 1, ovr: 1'b0};
    sb.push_back(ex);
    stream({8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01}, 0);
    wait_done(0);

    ex = '{legal: 1'b0, kind: 2'b01, fa: 3'd5, fb: 3'd5, lat: 1, ovr: 1'b0};
    brd = LEGAL; brd[40 +: 8] = 8'h11;
    sb.push_back(ex);
    stream(brd, 0);
    wait_done(0);
    brd[40 +: 8] = 8'h00;
    sb.push_back(ex);
    stream(brd, 0);
    wait_done(0);

    ex = '{legal: 1'b0, kind: 2'b10, fa: 3'd0, fb: 3'd1, lat: 1, ovr: 1'b0};
    sb.push_back(ex);
    stream({8'h08, 8'h02, 8'h40, 8'h04, 8'h20, 8'h80, 8'h01, 8'h01}, 0);
    wait_done(0);

    brd = LEGAL; brd[56 +: 8] = 8'h80;
    run(brd, 0, 0);

    // Gap between rows 3 and 4 plus a stray pulse during CHECK.
    run(LEGAL, 3, 5);
    run(LEGAL, 0, 0);

    // Reset ten edges into CHECK discards the board.
    stream(LEGAL, 0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("midrst");
    run(LEGAL, 0, 0);

    for (int b = 0; b < 8; b++) begin
      for (int r = 0; r < 8; r++) perm[r] = r;
      for (int r = 7; r > 0; r--) begin
        k = int'($urandom_range(r, 0));
        t = perm[r]; perm[r] = perm[k]; perm[k] = t;
      end
      for (int r = 0; r < 8; r++) brd[8*r +: 8] = 8'(1 << perm[r]);
      if (b == 6) brd[8*int'($urandom_range(7, 0)) +: 8] = 8'($urandom_range(255, 0));
      run(brd, 0, 0);
    end

    @(negedge clk);
    check_val("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
